// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready pipelined ALU.
// Stage 1 registers the operands and the opcode. The ALU itself is
// combinational between the two stages. Stage 2 registers the result and
// the NZCV flags. A sticky overflow bit records any retired ADD/SUB whose
// signed result overflowed.

module alu_pipe #(
    parameter int WIDTH = 36
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_op,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [3:0]       o_flags,
    output logic             o_ovf_sticky,
    input  logic             i_ovf_clr
);

    // Shift amount width, derived from the operand width
    localparam int SHW = $clog2(WIDTH);

    // Any shift amount at or above this value pushes every bit out
    localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH'(WIDTH);

    // Opcode encodings
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    // Stage 1 holding registers
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;

    // Stage 2 holding registers
    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    logic [3:0]       s2_flags;

    logic             ovf_sticky;

    // Pipeline advance enables
    logic             s1_adv;
    logic             s2_adv;

    // Combinational ALU datapath
    logic [WIDTH:0]   add_ext;
    logic [WIDTH-1:0] sub_res;
    logic             sub_borrow;
    logic             add_ovf;
    logic             sub_ovf;
    logic             slt_bit;
    logic [SHW-1:0]   sh_amt;
    logic             sh_oob;
    logic [WIDTH-1:0] sll_res;
    logic [WIDTH-1:0] srl_res;
    logic [WIDTH-1:0] alu_result;
    logic             alu_c;
    logic             alu_v;
    logic [3:0]       alu_flags;

    logic             out_fire;
    logic             ovf_retire;

    // A stage may move forward when it is empty or its successor is moving.
    // An empty stage therefore always accepts, which collapses bubbles.
    assign s2_adv = !s2_valid || i_out_ready;
    assign s1_adv = !s1_valid || s2_adv;

    // Ready is forced low during reset so no beat is taken while flushing
    assign o_in_ready = s1_adv && !i_rst;

    assign o_out_valid  = s2_valid;
    assign o_result     = s2_result;
    assign o_flags      = s2_flags;
    assign o_ovf_sticky = ovf_sticky;

    // Adder and subtractor share the stage-1 operands; carry comes from the
    // extra top bit of the widened sum, borrow from an unsigned compare.
    assign add_ext    = {1'b0, s1_a} + {1'b0, s1_b};
    assign sub_res    = s1_a - s1_b;
    assign sub_borrow = s1_a < s1_b;

    // Signed overflow: ADD overflows when both operands share a sign the
    // result lacks; SUB when operand signs differ and the result flips
    // away from the sign of a.
    assign add_ovf = (s1_a[WIDTH-1] == s1_b[WIDTH-1])
                  && (add_ext[WIDTH-1] != s1_a[WIDTH-1]);
    assign sub_ovf = (s1_a[WIDTH-1] != s1_b[WIDTH-1])
                  && (sub_res[WIDTH-1] != s1_a[WIDTH-1]);

    assign slt_bit = $signed(s1_a) < $signed(s1_b);

    // The whole of b is range-checked, so an amount like 64 (low bits zero)
    // still clears the result instead of aliasing to a shift of 0.
    assign sh_amt  = s1_b[SHW-1:0];
    assign sh_oob  = s1_b >= SHIFT_LIMIT;
    assign sll_res = sh_oob ? '0 : (s1_a << sh_amt);
    assign srl_res = sh_oob ? '0 : (s1_a >> sh_amt);

    // Result, carry and overflow selection by opcode
    always_comb begin
        alu_result = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        case (s1_op)
            OP_ADD: begin
                alu_result = add_ext[WIDTH-1:0];
                alu_c      = add_ext[WIDTH];
                alu_v      = add_ovf;
            end
            OP_SUB: begin
                alu_result = sub_res;
                alu_c      = sub_borrow;
                alu_v      = sub_ovf;
            end
            OP_AND: alu_result = s1_a & s1_b;
            OP_OR:  alu_result = s1_a | s1_b;
            OP_XOR: alu_result = s1_a ^ s1_b;
            OP_SLT: alu_result = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_SLL: alu_result = sll_res;
            OP_SRL: alu_result = srl_res;
            default: alu_result = '0;
        endcase
    end

    assign alu_flags = {alu_result[WIDTH-1], (alu_result == '0), alu_c, alu_v};

    // A retiring beat carries V=1 only if it was an overflowing ADD/SUB
    assign out_fire   = s2_valid && i_out_ready;
    assign ovf_retire = out_fire && s2_flags[0];

    // Stage 1: capture operands only for a real incoming beat so idle or
    // undefined inputs never disturb the held state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_ADD;
        end else if (s1_adv) begin
            s1_valid <= i_in_valid;
            if (i_in_valid) begin
                s1_a  <= i_a;
                s1_b  <= i_b;
                s1_op <= i_op;
            end
        end
    end

    // Stage 2: latch the computed result and flags when the slot frees up
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_flags  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= alu_result;
                s2_flags  <= alu_flags;
            end
        end
    end

    // Sticky overflow: a retiring overflow beat beats a simultaneous clear
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ovf_sticky <= 1'b0;
        end else if (ovf_retire) begin
            ovf_sticky <= 1'b1;
        end else if (i_ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed tests for alu_pipe with a scoreboard model that
// predicts every retired beat and the sticky overflow bit.

module tb_alu_pipe;

    localparam int W = 36;

    logic          i_clk;
    logic          i_rst;
    logic          i_in_valid;
    logic          o_in_ready;
    logic [W-1:0]  i_a;
    logic [W-1:0]  i_b;
    logic [2:0]    i_op;
    logic          o_out_valid;
    logic          i_out_ready;
    logic [W-1:0]  o_result;
    logic [3:0]    o_flags;
    logic          o_ovf_sticky;
    logic          i_ovf_clr;

    int assert_count = 0;
    int fail_count   = 0;
    int out_count    = 0;

    logic [39:0] exp_q[$];
    logic        model_sticky;
    logic        prev_hold;
    logic [W-1:0] prev_result;
    logic [3:0]  prev_flags;
    logic [39:0] mon_exp;
    logic        mon_next_sticky;

    alu_pipe #(.WIDTH(W)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .i_a          (i_a),
        .i_b          (i_b),
        .i_op         (i_op),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_result     (o_result),
        .o_flags      (o_flags),
        .o_ovf_sticky (o_ovf_sticky),
        .i_ovf_clr    (i_ovf_clr)
    );

    // Free-running clock, 10 time units per period
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Single comparison point: counts and reports
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference behaviour from the operation definitions, using signed
    // integer arithmetic for overflow. Packs {result, N, Z, C, V}.
    function automatic logic [39:0] model(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [2:0] op);
        longint sa, sb, sres;
        logic [W:0]   wide;
        logic [W-1:0] r;
        logic         c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            3'b000: begin
                wide = {1'b0, a} + {1'b0, b};
                r    = wide[W-1:0];
                c    = wide[W];
                sres = sa + sb;
                v    = (sres > 64'sd34359738367) || (sres < -64'sd34359738368);
            end
            3'b001: begin
                r    = a - b;
                c    = (a < b);
                sres = sa - sb;
                v    = (sres > 64'sd34359738367) || (sres < -64'sd34359738368);
            end
            3'b010: r = a & b;
            3'b011: r = a | b;
            3'b100: r = a ^ b;
            3'b101: r = (sa < sb) ? 36'd1 : 36'd0;
            3'b110: r = (b >= 36'd36) ? 36'd0 : (a << b);
            default: r = (b >= 36'd36) ? 36'd0 : (a >> b);
        endcase
        return {r, r[W-1], (r == '0), c, v};
    endfunction

    // Compare process: each falling edge predicts the transfers happening at
    // the next rising edge and checks what the DUT is presenting
    always @(negedge i_clk) begin
        if (i_rst) begin
            exp_q.delete();
            model_sticky = 1'b0;
            prev_hold    = 1'b0;
            checkOutput("rst_out_valid", 64'(o_out_valid), 64'(0));
            checkOutput("rst_in_ready", 64'(o_in_ready), 64'(0));
            checkOutput("rst_sticky", 64'(o_ovf_sticky), 64'(0));
            checkOutput("rst_result", 64'(o_result), 64'(0));
            checkOutput("rst_flags", 64'(o_flags), 64'(0));
        end else begin
            checkOutput("sticky", 64'(o_ovf_sticky), 64'(model_sticky));
            if (prev_hold) begin
                checkOutput("hold_valid", 64'(o_out_valid), 64'(1));
                checkOutput("hold_result", 64'(o_result), 64'(prev_result));
                checkOutput("hold_flags", 64'(o_flags), 64'(prev_flags));
            end
            mon_next_sticky = model_sticky;
            if (i_ovf_clr) mon_next_sticky = 1'b0;
            if (o_out_valid && i_out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("sb_unexpected_beat", 64'(1), 64'(0));
                end else begin
                    mon_exp = exp_q.pop_front();
                    checkOutput("sb_result", 64'(o_result), 64'(mon_exp[39:4]));
                    checkOutput("sb_flags", 64'(o_flags), 64'(mon_exp[3:0]));
                    out_count++;
                    if (mon_exp[0]) mon_next_sticky = 1'b1;
                end
            end
            model_sticky = mon_next_sticky;
            if (i_in_valid && o_in_ready) exp_q.push_back(model(i_a, i_b, i_op));
            prev_hold   = o_out_valid && !i_out_ready;
            prev_result = o_result;
            prev_flags  = o_flags;
        end
    end

    // One beat into an idle pipeline, exact two-edge latency, literal result
    task automatic applyStimulus(input string name, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [2:0] op,
                                 input logic [W-1:0] exp_r, input logic [3:0] exp_f);
        @(posedge i_clk); #1;
        i_in_valid = 1'b1;
        i_a = a;
        i_b = b;
        i_op = op;
        @(posedge i_clk); #1;
        i_in_valid = 1'b0;
        i_op = 3'bx;
        checkOutput({name, "_early"}, 64'(o_out_valid), 64'(0));
        @(posedge i_clk); #1;
        checkOutput({name, "_valid"}, 64'(o_out_valid), 64'(1));
        checkOutput({name, "_result"}, 64'(o_result), 64'(exp_r));
        checkOutput({name, "_flags"}, 64'(o_flags), 64'(exp_f));
    endtask

    // Global watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    int start_count;
    int waited;

    initial begin
        i_rst       = 1'b1;
        i_in_valid  = 1'b0;
        i_a         = '0;
        i_b         = '0;
        i_op        = 3'b000;
        i_out_ready = 1'b1;
        i_ovf_clr   = 1'b0;
        model_sticky = 1'b0;
        prev_hold    = 1'b0;
        #2;
        checkOutput("reset_out_valid", 64'(o_out_valid), 64'(0));
        checkOutput("reset_in_ready", 64'(o_in_ready), 64'(0));
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        #1 checkOutput("release_in_ready", 64'(o_in_ready), 64'(1));

        $display("[TB] T1 add carry");
        applyStimulus("t1_add", 36'hF_FFFF_FFFF, 36'd1, 3'b000, 36'd0, 4'b0110);

        $display("[TB] T2 add overflow and sticky");
        applyStimulus("t2_add", 36'h7_FFFF_FFFF, 36'd1, 3'b000, 36'h8_0000_0000, 4'b1001);
        @(posedge i_clk); #1;
        checkOutput("t2_sticky_set", 64'(o_ovf_sticky), 64'(1));
        i_ovf_clr = 1'b1;
        @(posedge i_clk); #1;
        i_ovf_clr = 1'b0;
        checkOutput("t2_sticky_clr", 64'(o_ovf_sticky), 64'(0));
        applyStimulus("t2_sub_ovf", 36'h8_0000_0000, 36'd1, 3'b001, 36'h7_FFFF_FFFF, 4'b0001);
        i_ovf_clr = 1'b1;
        @(posedge i_clk); #1;
        i_ovf_clr = 1'b0;
        checkOutput("t2_set_beats_clr", 64'(o_ovf_sticky), 64'(1));
        i_ovf_clr = 1'b1;
        @(posedge i_clk); #1;
        i_ovf_clr = 1'b0;

        $display("[TB] T3 sub and slt");
        applyStimulus("t3_sub", 36'd3, 36'd5, 3'b001, 36'hF_FFFF_FFFE, 4'b1010);
        applyStimulus("t3_slt_neg", 36'hF_FFFF_FFFF, 36'd1, 3'b101, 36'd1, 4'b0000);
        applyStimulus("t3_slt_pos", 36'd1, 36'hF_FFFF_FFFF, 3'b101, 36'd0, 4'b0100);

        $display("[TB] logic ops");
        applyStimulus("and", 36'hF_0F0F_0F0F, 36'h0_FF00_FF00, 3'b010, 36'h0_0F00_0F00, 4'b0000);
        applyStimulus("or",  36'hF_0F0F_0F0F, 36'h0_FF00_FF00, 3'b011, 36'hF_FF0F_FF0F, 4'b1000);
        applyStimulus("xor", 36'hF_0F0F_0F0F, 36'h0_FF00_FF00, 3'b100, 36'hF_F00F_F00F, 4'b1000);

        $display("[TB] T4 shifts");
        applyStimulus("t4_sll35", 36'd1, 36'd35, 3'b110, 36'h8_0000_0000, 4'b1000);
        applyStimulus("t4_sll36", 36'd1, 36'd36, 3'b110, 36'd0, 4'b0100);
        applyStimulus("t4_sll64", 36'd5, 36'd64, 3'b110, 36'd0, 4'b0100);
        applyStimulus("t4_srl35", 36'h8_0000_0000, 36'd35, 3'b111, 36'd1, 4'b0000);
        applyStimulus("t4_srl4", 36'h0_0000_0F00, 36'd4, 3'b111, 36'h0_0000_00F0, 4'b0000);
        @(posedge i_clk); #1;

        $display("[TB] T5 stream with stall");
        start_count = out_count;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    i_in_valid = 1'b1;
                    i_a  = 36'(i * 1000 + 7);
                    i_b  = 36'(i * 3 + 1);
                    i_op = 3'b000;
                    waited = 0;
                    while (1) begin
                        @(negedge i_clk);
                        if (o_in_ready) break;
                        waited++;
                        if (waited > 50) begin
                            checkOutput("t5_accept_timeout", 64'(1), 64'(0));
                            break;
                        end
                    end
                    @(posedge i_clk); #1;
                end
                i_in_valid = 1'b0;
                i_op = 3'bx;
            end
            begin
                repeat (3) @(posedge i_clk);
                #1 i_out_ready = 1'b0;
                repeat (4) @(posedge i_clk);
                #1;
                checkOutput("t5_in_ready_stalled", 64'(o_in_ready), 64'(0));
                checkOutput("t5_out_valid_stalled", 64'(o_out_valid), 64'(1));
                @(posedge i_clk);
                #1 i_out_ready = 1'b1;
            end
        join
        waited = 0;
        while ((out_count - start_count) < 8 && waited < 50) begin
            @(posedge i_clk);
            waited++;
        end
        #1;
        checkOutput("t5_beat_count", 64'(out_count - start_count), 64'(8));
        checkOutput("t5_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] T6 reset mid-stall");
        applyStimulus("t6_pre_ovf", 36'h4_0000_0000, 36'h4_0000_0000, 3'b000, 36'h8_0000_0000, 4'b1001);
        @(posedge i_clk); #1;
        checkOutput("t6_sticky_before", 64'(o_ovf_sticky), 64'(1));
        i_out_ready = 1'b0;
        i_in_valid = 1'b1;
        i_a = 36'd10; i_b = 36'd20; i_op = 3'b000;
        @(posedge i_clk); #1;
        i_a = 36'd30; i_b = 36'd40;
        @(posedge i_clk); #1;
        i_in_valid = 1'b0;
        i_op = 3'bx;
        @(posedge i_clk); #1;
        checkOutput("t6_in_ready_full", 64'(o_in_ready), 64'(0));
        i_rst = 1'b1;
        #1;
        checkOutput("t6_out_valid_rst", 64'(o_out_valid), 64'(0));
        checkOutput("t6_sticky_rst", 64'(o_ovf_sticky), 64'(0));
        checkOutput("t6_in_ready_rst", 64'(o_in_ready), 64'(0));
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        i_out_ready = 1'b1;
        #1 checkOutput("t6_in_ready_after", 64'(o_in_ready), 64'(1));
        applyStimulus("t6_post", 36'd2, 36'd3, 3'b000, 36'd5, 4'b0000);
        repeat (3) @(posedge i_clk);
        #1 checkOutput("t6_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
